// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage sitting right after the PC register. Reads the
//   current PC, issues a read to the instruction cache and holds it until the
//   response, and tells the PC register what to load next: pc+4 after a
//   completed fetch, or the redirect target. Fetched words land in the IF/ID
//   register; a one-entry skid buffer absorbs a response that arrives while
//   decode is stalled. A redirect flushes IF/ID and the skid, and cancels an
//   outstanding cache read by draining its response (DROP state).
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pc_in                    current PC from the PC register
//   pc_load, pc_next         load strobe / value for the PC register
//   imem_read, imem_address  I-cache request (held until imem_resp)
//   imem_resp, imem_rdata    I-cache one-cycle completion and data
//   stall_in                 decode cannot accept IF/ID this cycle
//   redirect_valid/_target   one-cycle flush and new PC from a later stage
//   if_valid, if_pc, if_instr  IF/ID register contents
module fetch_stage #(
  parameter int unsigned        WIDTH = 32,
  parameter logic [WIDTH-1:0]   NOP   = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic             imem_resp,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall_in,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t           state_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] skid_pc_reg;
  logic [WIDTH-1:0] skid_instr_reg;
  logic             if_valid_reg;
  logic [WIDTH-1:0] if_pc_reg;
  logic [WIDTH-1:0] if_instr_reg;
  logic             slot_free;

  assign slot_free = !if_valid_reg || !stall_in;

  // The cache handshake and PC-register strobe have to react in the same
  // cycle as imem_resp / redirect_valid, so they are decoded combinationally
  // from the registered state.
  always_comb begin
    imem_read    = 1'b0;
    imem_address = addr_reg;
    pc_load      = 1'b0;
    pc_next      = pc_in + PC_STEP;
    if (!rst) begin
      case (state_reg)
        FETCH: begin
          imem_read    = 1'b1;
          imem_address = pc_in;
          pc_load      = imem_resp;
        end
        DROP: begin
          // Keep presenting the cancelled request until its response drains.
          imem_read    = 1'b1;
          imem_address = addr_reg;
        end
        default: ;
      endcase
      if (redirect_valid) begin
        pc_load = 1'b1;
        pc_next = redirect_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH;
      addr_reg       <= '0;
      skid_pc_reg    <= '0;
      skid_instr_reg <= '0;
      if_valid_reg   <= 1'b0;
      if_pc_reg      <= '0;
      if_instr_reg   <= NOP;
    end else begin
      // Track the address of the read currently on the bus, so a redirect
      // arriving mid-read knows which request it must drain.
      if (state_reg == FETCH) begin
        addr_reg <= pc_in;
      end
      if (redirect_valid) begin
        if_valid_reg <= 1'b0;
        if_instr_reg <= NOP;
        case (state_reg)
          FETCH:   state_reg <= imem_resp ? FETCH : DROP;
          HOLD:    state_reg <= FETCH;   // leaving HOLD empties the skid
          default: state_reg <= DROP;
        endcase
      end else begin
        case (state_reg)
          FETCH: begin
            if (imem_resp) begin
              if (slot_free) begin
                if_valid_reg <= 1'b1;
                if_pc_reg    <= pc_in;
                if_instr_reg <= imem_rdata;
              end else begin
                skid_pc_reg    <= pc_in;
                skid_instr_reg <= imem_rdata;
                state_reg      <= HOLD;
              end
            end else if (slot_free) begin
              if_valid_reg <= 1'b0;
            end
          end
          HOLD: begin
            if (slot_free) begin
              if_valid_reg <= 1'b1;
              if_pc_reg    <= skid_pc_reg;
              if_instr_reg <= skid_instr_reg;
              state_reg    <= FETCH;
            end
          end
          default: begin
            if (slot_free) begin
              if_valid_reg <= 1'b0;
            end
            if (imem_resp) begin
              state_reg <= FETCH;
            end
          end
        endcase
      end
    end
  end

  assign if_valid = if_valid_reg;
  assign if_pc    = if_pc_reg;
  assign if_instr = if_instr_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. Models the PC register around the DUT,
//   drives cache responses by hand, and keeps a queue of {pc, instr} entries
//   that are expected to appear on IF/ID.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_load         (pc_load),
    .pc_next         (pc_next),
    .imem_read       (imem_read),
    .imem_address    (imem_address),
    .imem_resp       (imem_resp),
    .imem_rdata      (imem_rdata),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  // PC register the fetch stage drives
  always @(posedge clk) begin
    if (rst) pc_in <= 32'h60;
    else if (pc_load) pc_in <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with a cache response for the read at exp_pc; the entry is
  // expected either on IF/ID or in the skid, so it is queued either way.
  task automatic resp_cycle(input string tag, input logic [31:0] data);
    imem_resp  = 1'b1;
    imem_rdata = data;
    #1;
    chk({tag, ".imem_read"}, 32'(imem_read), 32'd1);
    chk({tag, ".imem_address"}, imem_address, exp_pc);
    chk({tag, ".pc_load"}, 32'(pc_load), 32'd1);
    chk({tag, ".pc_next"}, pc_next, exp_pc + 32'd4);
    sb_q.push_back({exp_pc, data});
    $display("resp   %s pc=%h instr=%h", tag, exp_pc, data);
    exp_pc = exp_pc + 32'd4;
    tick();
    imem_resp = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, ".if_valid"}, 32'(if_valid), 32'd1);
      chk({tag, ".if_pc"}, if_pc, e[63:32]);
      chk({tag, ".if_instr"}, if_instr, e[31:0]);
      $display("ifid   %s pc=%h instr=%h", tag, if_pc, if_instr);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; stall_in = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    tick(); tick();

    // reset state
    chk("rst.if_valid", 32'(if_valid), 32'd0);
    chk("rst.if_pc", if_pc, 32'h0);
    chk("rst.if_instr", if_instr, NOP);
    chk("rst.imem_read", 32'(imem_read), 32'd0);
    chk("rst.pc_load", 32'(pc_load), 32'd0);
    $display("reset  checked");

    // 1: response after two waiting cycles
    rst = 1'b0;
    exp_pc = 32'h60;
    #1;
    chk("t1.read", 32'(imem_read), 32'd1);
    chk("t1.addr", imem_address, 32'h60);
    chk("t1.no_load", 32'(pc_load), 32'd0);
    tick(); tick();
    chk("t1.wait_addr", imem_address, 32'h60);
    resp_cycle("t1", 32'h00500093);
    pop_check("t1");

    // 2: back-to-back responses, no bubbles
    resp_cycle("t2a", 32'h00100113);
    pop_check("t2a");
    resp_cycle("t2b", 32'h00200193);
    pop_check("t2b");
    resp_cycle("t2c", 32'h00300213);
    pop_check("t2c");

    // 3: stall with IF/ID full, response goes to skid, HOLD
    stall_in = 1'b1;
    tick();
    chk("t3.held_valid", 32'(if_valid), 32'd1);
    chk("t3.held_pc", if_pc, 32'h6C);
    resp_cycle("t3", 32'h00400293);
    chk("t3.hold_read", 32'(imem_read), 32'd0);
    chk("t3.hold_pc", if_pc, 32'h6C);
    tick();
    chk("t3.hold_read2", 32'(imem_read), 32'd0);
    chk("t3.hold_pcload", 32'(pc_load), 32'd0);
    stall_in = 1'b0;
    tick();
    pop_check("t3");
    #1;
    chk("t3.resume_read", 32'(imem_read), 32'd1);
    chk("t3.resume_addr", imem_address, 32'h74);

    // 4: redirect with a read to 0x74 outstanding -> DROP
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    #1;
    chk("t4.pc_load", 32'(pc_load), 32'd1);
    chk("t4.pc_next", pc_next, 32'h200);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4.if_valid", 32'(if_valid), 32'd0);
    chk("t4.if_instr", if_instr, NOP);
    chk("t4.drop_read", 32'(imem_read), 32'd1);
    chk("t4.drop_addr", imem_address, 32'h74);
    imem_resp  = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("t4.drop_pcload", 32'(pc_load), 32'd0);
    tick();
    imem_resp = 1'b0;
    #1;
    chk("t4.after_valid", 32'(if_valid), 32'd0);
    chk("t4.new_addr", imem_address, 32'h200);
    $display("redir  t4 target=200 dropped=74");
    exp_pc = 32'h200;
    resp_cycle("t4", 32'h00600313);
    pop_check("t4");

    // 5: redirect in the same cycle as a response
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    imem_resp       = 1'b1;
    imem_rdata      = 32'hCAFEF00D;
    #1;
    chk("t5.pc_load", 32'(pc_load), 32'd1);
    chk("t5.pc_next", pc_next, 32'h300);
    tick();
    redirect_valid = 1'b0;
    imem_resp      = 1'b0;
    #1;
    chk("t5.if_valid", 32'(if_valid), 32'd0);
    chk("t5.if_instr", if_instr, NOP);
    chk("t5.fetch_addr", imem_address, 32'h300);
    chk("t5.fetch_read", 32'(imem_read), 32'd1);
    $display("redir  t5 target=300 same-cycle resp");
    exp_pc = 32'h300;

    // 6: reset while HOLD with the skid full
    resp_cycle("t6a", 32'h00700393);
    pop_check("t6a");
    stall_in = 1'b1;
    resp_cycle("t6b", 32'h00800413);
    chk("t6.hold_read", 32'(imem_read), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6.rst_read", 32'(imem_read), 32'd0);
    tick();
    rst      = 1'b0;
    stall_in = 1'b0;
    sb_q.delete();
    #1;
    chk("t6.if_valid", 32'(if_valid), 32'd0);
    chk("t6.if_instr", if_instr, NOP);
    chk("t6.fetch_read", 32'(imem_read), 32'd1);
    chk("t6.fetch_addr", imem_address, 32'h60);
    $display("reset  t6 mid-hold checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
